// File: rtl/logic_fifo_arb_pkg.sv
// logic_fifo_arb_pkg: shared state encoding, width helper and default sizes for the FIFO write arbiter.
package logic_fifo_arb_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_WIDTH = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Ceiling log2, used to size the grant index from the requester count
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/logic_fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker returning the first eligible requester at or after start.
module rr_pick
    import logic_fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    input  logic [N_REQ-1:0] excl,
    output logic [ID_W-1:0]  winner,
    output logic             found
);
    logic [N_REQ-1:0]   avail;
    logic [2*N_REQ-1:0] rot;

    assign avail = req & ~excl;
    assign rot   = {avail, avail} >> start;

    // Lowest set bit of the rotated view is the nearest requester after start; the
    // modulo keeps the index in range for non-power-of-two counts
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = ID_W'((int'(start) + k) % N_REQ);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_fifo_wr_arbiter.sv
// logic_fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ valid/ready streams.
// Define LOGIC_FIFO_ARB_BURST_LOCK_EN to hold a grant until the requester's req_last beat is accepted.
module logic_fifo_wr_arbiter
    import logic_fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_W       = clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       fifo_di,
    output logic                        fifo_we,
    input  logic                        fifo_full,
    input  logic                        fifo_afull,
    output logic [ID_W-1:0]             grant_id,
    output logic                        grant_vld
);
`ifdef LOGIC_FIFO_ARB_BURST_LOCK_EN
    localparam bit BURST_LOCK = 1'b1;
`else
    localparam bit BURST_LOCK = 1'b0;
`endif

    state_t                state, state_nxt;
    logic [ID_W-1:0]       last_grant, last_nxt, grant_nxt, base, start, winner;
    logic [N_REQ-1:0]      gnt_oh, excl;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  stall, sel_valid, accept, rearb, found;

    assign stall     = fifo_afull | fifo_full;
    assign sel_valid = |(req_valid & gnt_oh);
    assign accept    = (state == GRANT) & sel_valid & ~stall;
    assign req_ready = accept ? gnt_oh : '0;
    assign grant_vld = (state == GRANT);
    assign rearb     = !BURST_LOCK || |(req_last & gnt_oh);

    // From IDLE the search follows last_grant; on an accept the granted index becomes last_grant
    assign base  = (state == GRANT) ? grant_id : last_grant;
    assign start = (base == ID_W'(N_REQ - 1)) ? '0 : base + 1'b1;
    // The current holder competes again only when nobody else is waiting
    assign excl  = ((state == GRANT) && |(req_valid & ~gnt_oh)) ? gnt_oh : '0;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_valid),
        .start  (start),
        .excl   (excl),
        .winner (winner),
        .found  (found)
    );

    // Decode the held grant into a one-hot mask and select its data word
    always_comb begin
        gnt_oh   = '0;
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                gnt_oh[k] = 1'b1;
                sel_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next grant: start from IDLE, re-arbitrate on accept, release when the holder goes away
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        if (state == IDLE) begin
            if (|req_valid && !stall) begin
                state_nxt = GRANT;
                grant_nxt = winner;
            end
        end else if (accept) begin
            last_nxt = grant_id;
            if (rearb) begin
                state_nxt = found ? GRANT : IDLE;
                grant_nxt = found ? winner : grant_id;
            end
        end else if (!stall && !sel_valid && !BURST_LOCK) begin
            state_nxt = IDLE;
        end
    end

    // Grant state and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    // Registered FIFO write port; data holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_we <= 1'b0;
            fifo_di <= '0;
        end else begin
            fifo_we <= accept;
            if (accept) fifo_di <= sel_data;
        end
    end

endmodule

// File: tb/tb_logic_fifo_wr_arbiter.sv
// tb_logic_fifo_wr_arbiter: randomized and directed checks of the FIFO write arbiter against a queue-based model.
module tb_logic_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 9;
`ifdef LOGIC_FIFO_ARB_BURST_LOCK_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   fifo_di;
    logic            fifo_we, fifo_full, fifo_afull, grant_vld;
    logic [1:0]      grant_id;

    logic_fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_di    (fifo_di),
        .fifo_we    (fifo_we),
        .fifo_full  (fifo_full),
        .fifo_afull (fifo_afull),
        .grant_id   (grant_id),
        .grant_vld  (grant_vld)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            pushed_n = 0;
    logic [DW-1:0] wq [N][$];
    bit            lq [N][$];
    logic [DW-1:0] log_q [$];
    int            wcyc [$];
    logic [N-1:0]  gate;
    bit            afull_v, full_v;
    bit            m_gv, m_we;
    int            m_gid, m_last;
    logic [DW-1:0] m_di;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next requester after 'from' in circular order; 'from' itself is skipped if others are valid
    function automatic int rr_next(input logic [N-1:0] v, input int from, input bit skip_from);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (v[i] && !(skip_from && i == from && v != (N'(1) << from))) return i;
        end
        return -1;
    endfunction

    task automatic push(input int id, input logic [DW-1:0] d, input bit l);
        wq[id].push_back(d);
        lq[id].push_back(l);
        pushed_n++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            wq[i].delete();
            lq[i].delete();
        end
        log_q.delete();
        wcyc.delete();
        pushed_n = 0;
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with reset released
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_we", fifo_we, 0);
        check("rst_di", fifo_di, 0);
        check("rst_gid", grant_id, 0);
        check("rst_gvld", grant_vld, 0);
        check("rst_ready", req_ready, 0);
        m_gv = 0; m_we = 0; m_gid = 0; m_last = N - 1; m_di = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycle();
        logic [N-1:0] v, m_ready;
        bit stall, acc, lst;
        int w;
        lst = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = gate[i] && wq[i].size() > 0;
            req_data[i*DW +: DW] = wq[i].size() > 0 ? wq[i][0] : '0;
            req_last[i] = wq[i].size() > 0 ? lq[i][0] : 1'b0;
        end
        req_valid  = v;
        fifo_afull = afull_v;
        fifo_full  = full_v;
        stall   = afull_v | full_v;
        m_ready = (m_gv && !stall) ? (v & (N'(1) << m_gid)) : '0;
        acc     = m_ready != 0;
        #4;
        check("ready", req_ready, m_ready);
        @(posedge clk);
        m_we = acc;
        if (acc) begin
            m_di = wq[m_gid].pop_front();
            lst  = lq[m_gid].pop_front();
        end
        if (!m_gv) begin
            if (v != 0 && !stall) begin
                m_gv  = 1;
                m_gid = rr_next(v, m_last, 0);
            end
        end else if (acc) begin
            m_last = m_gid;
            if (!BURST || lst) begin
                w = rr_next(v, m_gid, 1);
                if (w < 0) m_gv = 0;
                else m_gid = w;
            end
        end else if (!stall && !v[m_gid] && !BURST) begin
            m_gv = 0;
        end
        cyc++;
        #1;
        check("we", fifo_we, m_we);
        check("di", fifo_di, m_di);
        check("gvld", grant_vld, m_gv);
        check("gid", grant_id, m_gid);
        if (fifo_we) begin
            log_q.push_back(fifo_di);
            wcyc.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        int w;
        int exp_burst [6];
        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        fifo_afull = 1'b0; fifo_full = 1'b0;
        gate = '1; afull_v = 0; full_v = 0;
        @(posedge clk);
        #1;
        do_reset();

        // single requester, words 1..4
        clear_all();
        for (int s = 1; s <= 4; s++) push(0, DW'(s), 0);
        run(8);
        check("single_n", log_q.size(), 4);
        for (int s = 0; s < 4 && s < log_q.size(); s++) check("single_di", log_q[s], s + 1);
        if (wcyc.size() == 4) check("single_contig", wcyc[3] - wcyc[0], 3);

        // fairness with all requesters valid
        do_reset();
        clear_all();
        for (int s = 0; s < 6; s++)
            for (int id = 0; id < N; id++) push(id, {2'(id), 7'(s)}, 1);
        run(30);
        check("fair_n", log_q.size(), 24);
        for (int i = 0; i < log_q.size(); i++) check("fair_id", log_q[i][8:7], i % N);
        if (wcyc.size() > 0) check("fair_contig", wcyc[$] - wcyc[0] + 1, wcyc.size());

        // almost-full backpressure mid-stream
        do_reset();
        clear_all();
        for (int s = 0; s < 4; s++) begin
            push(0, {2'd0, 7'(s)}, 1);
            push(1, {2'd1, 7'(s)}, 1);
        end
        run(3);
        afull_v = 1;
        w = log_q.size();
        run(2);
        check("af_nowrite", log_q.size(), w);
        afull_v = 0;
        run(12);
        check("af_n", log_q.size(), 8);
        for (int i = 0; i < log_q.size(); i++) check("af_id", log_q[i][8:7], i % 2);

        // 3-word packet from req 1 against single-word packets from req 2
        do_reset();
        clear_all();
        for (int s = 0; s < 3; s++) begin
            push(1, {2'd1, 7'(s)}, s == 2);
            push(2, {2'd2, 7'(s)}, 1);
        end
        exp_burst = BURST ? '{1, 1, 1, 2, 2, 2} : '{1, 2, 1, 2, 1, 2};
        run(12);
        check("burst_n", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) check("burst_id", log_q[i][8:7], exp_burst[i]);

        // reset in the middle of a stream
        do_reset();
        clear_all();
        for (int s = 0; s < 4; s++)
            for (int id = 0; id < N; id++) push(id, {2'(id), 7'(s)}, 1);
        run(4);
        do_reset();
        clear_all();
        for (int s = 0; s < 4; s++)
            for (int id = 0; id < N; id++) push(id, {2'(id), 7'(s + 8)}, 1);
        run(20);
        check("rstmid_n", log_q.size(), 16);
        if (log_q.size() > 0) check("rstmid_first", log_q[0][8:7], 0);

        // randomized traffic with random backpressure
        do_reset();
        clear_all();
        for (int c = 0; c < 400; c++) begin
            for (int id = 0; id < N; id++)
                if (wq[id].size() < 3 && $urandom_range(0, 1) == 1)
                    push(id, DW'($urandom), $urandom_range(0, 2) == 0);
            gate    = N'($urandom);
            afull_v = $urandom_range(0, 9) == 0;
            full_v  = $urandom_range(0, 19) == 0;
            cycle();
        end
        for (int id = 0; id < N; id++) push(id, DW'($urandom), 1);
        gate = '1; afull_v = 0; full_v = 0;
        run(60);
        check("rand_drain", log_q.size(), pushed_n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_fifo_wr_arbiter.md
# logic_fifo_wr_arbiter

Round-robin write-side arbiter that shares one single-clock logic FIFO write port among N_REQ requesters. Each requester offers a valid/ready stream; the arbiter selects one requester per beat and registers the selected word onto the FIFO `di`/`we` port. It uses the FIFO's `afull_flag` and `full_flag` as backpressure. It sits between the bus-side requesters and the FIFO instance, in the same clock domain as the FIFO write clock.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 9: word width; must equal the FIFO write width.
- `ID_W`, clog2(N_REQ): width of the grant index.
- `clk`  in  1  clock; drives the FIFO write clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester word valid.
- `req_data`  in  N_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  N_REQ  last word of a packet; used only with burst lock.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `fifo_di`  out  DATA_WIDTH  registered write data to the FIFO.
- `fifo_we`  out  1  registered write enable to the FIFO.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_afull`  in  1  FIFO almost-full flag; the FIFO's AF threshold must be ≤ F-2.
- `grant_id`  out  ID_W  index of the current or last granted requester.
- `grant_vld`  out  1  a grant is currently held (state GRANT).

## Operation
- **Stall condition:** `stall = fifo_afull | fifo_full`. While stalled, `req_ready` is all zero.
- **States:** IDLE and GRANT.
- **IDLE:**
  - `req_ready` = 0.
  - If any `req_valid` and not stall, pick the winner with `rr_pick` and go to GRANT next cycle with `grant_id` set to the winner.
- **Round-robin search:** starts at (`last_grant`+1) mod N_REQ and wraps. `last_grant` resets to N_REQ-1, so requester 0 wins first.
- **GRANT:**
  - `req_ready[g] = req_valid[g] & ~stall`, where g = `grant_id`.
  - A beat is accepted when `req_valid[g] & req_ready[g]`.
  - On accept, `fifo_di` takes `req_data[g]` and `fifo_we` is 1 in the next cycle. Otherwise `fifo_we` is 0 next cycle and `fifo_di` holds its value.
- **GRANT transitions without burst lock:**
  - On accept, set `last_grant` to g, then re-arbitrate in the same cycle using `req_valid` with g excluded unless g is the only requester valid.
  - If a winner exists, stay in GRANT with the new `grant_id`; otherwise go to IDLE.
  - If `req_valid[g]` drops without an accept, go to IDLE.
- **Stall in GRANT:** the state and `grant_id` hold.
- **Arithmetic:** modulo N_REQ with wrap at N_REQ-1. Non-power-of-two N_REQ never yields an out-of-range index.

## Timing
- **Reset values:** `req_ready`=0, `fifo_we`=0, `fifo_di`=0, `grant_id`=0, `grant_vld`=0, state=IDLE, `last_grant`=N_REQ-1.
- **Latency:** IDLE to first accept is 1 cycle. Accept to `fifo_we` is 1 cycle.
- **Throughput:** 1 word per cycle while in GRANT, including back-to-back grant switches.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid`, `fifo_afull` and `fifo_full`.
- **Flag margin:** the FIFO flags lag one write because `fifo_we` is registered. AF ≤ F-2 guarantees no write reaches a full FIFO.
- **Reset mid-packet:** the grant and any pending `fifo_we` are dropped immediately.

## Configuration
- **Macro:** `LOGIC_FIFO_ARB_BURST_LOCK_EN`.
- **Defined:**
  - The grant is held until a beat with `req_last[g]` is accepted; only then does re-arbitration happen.
  - If `req_valid[g]` drops mid-packet, the arbiter stays in GRANT and other requesters wait.
  - Words of one packet are contiguous in the FIFO.
- **Undefined:** `req_last` is ignored, and arbitration is per beat as described in Operation.

## Structure
- **Shared package `logic_fifo_arb_pkg`:** state enum (IDLE, GRANT), `clog2` function, default width constants.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs: request vector, start index, exclude mask. Outputs: winner index and found flag.

## Test plan
- **Single requester:** only req 0 valid with words 0x001..0x004. Expect `req_ready[0]` from cycle 1, `fifo_we` high for 4 cycles, `fifo_di` = 0x001..0x004 one cycle after each accept.
- **Fairness:** all 4 valid continuously. Expect grant order 0,1,2,3,0,… with no idle cycles and `fifo_we` continuously high.
- **Almost-full backpressure:** assert `fifo_afull` mid-stream. Expect `req_ready` = 0 in the same cycle, at most one further `fifo_we` (the already-registered write), and the same grant resuming when `fifo_afull` drops.
- **Burst lock:** with `LOGIC_FIFO_ARB_BURST_LOCK_EN`, req 1 sends a 3-word packet while req 2 is valid. Expect 3 consecutive req-1 words, then req 2. Without the macro, expect interleaving 1,2,1,2,1.
- **Reset mid-stream:** assert `rst` during GRANT. Expect all outputs 0 immediately and, after release, requester 0 winning first.
